// File: rtl/stack_pkg.sv
// Shared constants and types for the operand stack: default geometry,
// push-source encodings and the error-status state encoding.
package stack_pkg;

  localparam int WORD_W      = 8;
  localparam int STACK_DEPTH = 8;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MDR = 1'b1;

  typedef enum logic {
    ERR_OK  = 1'b0,
    ERR_SET = 1'b1
  } stack_err_e;

  // Pointer width able to hold every value 0..depth inclusive.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x WIDTH registers, async clear, one synchronous
// write port and one combinational read port.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_we_vec;

  // One-hot write enable so each entry sees a simple load condition.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign w_we_vec[gi] = i_we && (i_waddr == AW'(gi));
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we_vec[i]) begin
          r_mem[i] <= i_wdata;
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the stack-machine datapath: owns the stack pointer,
// push-data select, occupancy flags and the sticky error state machine.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     stack_src,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic [WIDTH-1:0]         mdr,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         tos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0] r_sp;
  logic [PTR_W-1:0] w_sp_next;
  logic             w_empty;
  logic             w_full;
  logic [WIDTH-1:0] w_push_data;
  logic             w_replace;
  logic             w_we;
  logic [AW-1:0]    w_top_addr;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_ovf_ev;
  logic             w_udf_ev;

  stack_err_e       r_err_state;
  stack_err_e       w_err_next;
  logic             r_ovf;
  logic             r_udf;
  logic             w_ovf_next;
  logic             w_udf_next;

  assign w_empty     = (r_sp == '0);
  assign w_full      = (r_sp == PTR_W'(DEPTH));
  assign w_push_data = (stack_src == SRC_MDR) ? mdr : alu_result;

  // Low bits of sp-1 wrap to DEPTH-1 when the stack is full, which is the top.
  assign w_top_addr  = r_sp[AW-1:0] - AW'(1);

  // Push+pop on a non-empty stack overwrites the top in place.
  assign w_replace   = push && pop && !w_empty;
  assign w_we        = push && (w_replace || !w_full);
  assign w_waddr     = w_replace ? w_top_addr : r_sp[AW-1:0];

  assign w_ovf_ev    = push && !pop && w_full;
  assign w_udf_ev    = pop && !push && w_empty;

  always_comb begin
    w_sp_next = r_sp;
    if (push && !pop && !w_full) begin
      w_sp_next = r_sp + PTR_W'(1);
    end else if (push && pop && w_empty) begin
      w_sp_next = r_sp + PTR_W'(1);
    end else if (pop && !push && !w_empty) begin
      w_sp_next = r_sp - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= '0;
    end else begin
      r_sp <= w_sp_next;
    end
  end

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .i_rst_n (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_push_data),
    .i_raddr (w_top_addr),
    .o_rdata (w_rd_data)
  );

  // Error machine: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_state <= ERR_OK;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_err_state <= w_err_next;
      r_ovf       <= w_ovf_next;
      r_udf       <= w_udf_next;
    end
  end

  // Error machine: next state; a fresh event always beats clear_err.
  always_comb begin
    w_err_next = r_err_state;
    w_ovf_next = r_ovf;
    w_udf_next = r_udf;
    case (r_err_state)
      ERR_OK: begin
        if (w_ovf_ev || w_udf_ev) begin
          w_err_next = ERR_SET;
          w_ovf_next = w_ovf_ev;
          w_udf_next = w_udf_ev;
        end
      end
      ERR_SET: begin
        if (w_ovf_ev || w_udf_ev) begin
          w_err_next = ERR_SET;
          w_ovf_next = w_ovf_ev || (r_ovf && !clear_err);
          w_udf_next = w_udf_ev || (r_udf && !clear_err);
        end else if (clear_err) begin
          w_err_next = ERR_OK;
          w_ovf_next = 1'b0;
          w_udf_next = 1'b0;
        end
      end
      default: begin
        w_err_next = ERR_OK;
        w_ovf_next = 1'b0;
        w_udf_next = 1'b0;
      end
    endcase
  end

  // Error machine and status outputs.
  always_comb begin
    overflow  = r_ovf;
    underflow = r_udf;
    empty     = w_empty;
    full      = w_full;
    count     = r_sp;
    tos       = w_empty ? '0 : w_rd_data;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

- Hardware operand stack for the multicycle stack-machine datapath.
- Sits directly downstream of the control unit:
  - consumes its `push`, `pop` and `stack_src` strobes;
  - stores the selected word (ALU result or memory data register);
  - presents the current top-of-stack to the A/B operand latches, to the memory write-data path, and back to the control unit for the conditional-jump zero test.
- Tracks occupancy and flags overflow/underflow errors.

## Interface

Parameters:
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 8, number of stack entries (power of two, ≥2)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `push`  in  1  write selected word as new top this cycle
- `pop`  in  1  discard current top this cycle
- `stack_src`  in  1  push-data select: 0 = `alu_result`, 1 = `mdr`
- `alu_result`  in  WIDTH  ALU output
- `mdr`  in  WIDTH  memory data register output
- `tos`  out  WIDTH  current top entry, combinational from state
- `count`  out  $clog2(DEPTH)+1  number of valid entries
- `empty`  out  1  `count == 0`
- `full`  out  1  `count == DEPTH`
- `overflow`  out  1  sticky: push attempted while full
- `underflow`  out  1  sticky: pop attempted while empty
- `clear_err`  in  1  synchronous clear of both sticky flags

## Operation

- Storage: DEPTH×WIDTH register array plus stack pointer `sp` (= `count`).
  - Entry `sp-1` is the top.
  - `sp` is $clog2(DEPTH)+1 bits wide, so the full value DEPTH is representable; no wrap-around.
- `tos` = entry[`sp-1`] when not empty; 0 when empty.
  - An empty stack reads as zero, so a conditional jump on an empty stack is taken.
- Push data: `stack_src ? mdr : alu_result`.
- Per rising edge, with `push`/`pop` sampled:
  - push only, not full: entry[`sp`] ← data; `sp` ← `sp+1`.
  - push only, full: no write; `sp` unchanged; `overflow` ← 1.
  - pop only, not empty: `sp` ← `sp-1`; entry contents unchanged.
  - pop only, empty: `sp` unchanged; `underflow` ← 1.
  - push and pop, not empty: replace top, i.e. entry[`sp-1`] ← data; `sp` unchanged.
  - push and pop, empty: behaves as push only; no underflow.
  - neither: hold.
- `clear_err` = 1: both sticky flags ← 0.
  - A new error in the same cycle wins: the flag is set.
- Error status state machine:
  - States: OK and ERR.
  - OK → ERR on any overflow or underflow event.
  - ERR → OK on `clear_err` with no concurrent event.
  - Flags are the registered outputs of this machine.
- Stack contents are not protected in ERR; normal push/pop continue.

## Timing

- Reset (`reset` = 0, asynchronous):
  - `sp` = 0; all entries = 0.
  - `tos` = 0, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0.
  - The error state machine returns to OK.
- Reset deassertion is synchronised externally; the block takes no action beyond the async clear.
- Pop latency 0 for reads:
  - the pre-edge `tos` is valid during the pop cycle, so a latch clocked on the same edge as `pop` captures the popped value;
  - the new `tos` is visible after that edge.
- Push latency 1: the pushed value appears on `tos` after the rising edge that sampled `push`.
- `count`, `empty`, `full` and the flags are registered or derived from registers, and update one edge after the causing strobe.
- Reset mid-operation: an in-flight push/pop is discarded; no partial update.

## Structure

- Shared package `stack_pkg`:
  - `WORD_W` = 8, `STACK_DEPTH` = 8;
  - `stack_src` encodings `SRC_ALU` = 1'b0, `SRC_MDR` = 1'b1;
  - enum `stack_err_e` {`ERR_OK`, `ERR_SET`}.
- One sub-module, `stack_regfile`:
  - DEPTH×WIDTH array, async-clear, one synchronous write port (addr, data, we), one combinational read port.
  - `stack_unit` owns `sp`, the data mux, the flags and the error state machine.

## Test plan

- Reset then idle → `tos` = 0, `count` = 0, `empty` = 1, flags 0.
- Push `alu_result` = 0x11, then push `mdr` = 0x22 (`stack_src` = 1) → `tos` 0x11 then 0x22; `count` = 2. Pop → `tos` = 0x11 in the cycle after the edge; value 0x22 is visible on `tos` during the pop cycle.
- Push 8 values 0x01..0x08, then a ninth push of 0xFF → `full` = 1, `overflow` = 1, `tos` stays 0x08, `count` = 8. Pulse `clear_err` → `overflow` = 0.
- From empty, pop → `underflow` = 1, `count` = 0, `tos` = 0. Pop + `clear_err` in the same cycle → `underflow` stays 1.
- Stack [0x05, 0x07], push + pop with `alu_result` = 0x0C → `tos` = 0x0C, `count` = 2, below-top entry still 0x05.
- After 3 pushes, assert `reset` = 0 asynchronously between clock edges → all outputs at reset values immediately, before the next edge.
